conv_window_buffer: RTL and testbench

- Sliding-window generator directly upstream of the convolution multiply-adder tree.
- Accepts a raster-order pixel stream, one pixel per cycle at most.
- Holds K-1 image lines in line buffers plus a KxK window register.
- Emits a flattened KxK window in the bit packing the multiply-adder expects, for every valid-mode convolution position (no padding).

---
 rtl/conv_window_buffer.sv | 175 +++++++++++++++++
 tb/tb_conv_window_buffer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_buffer.sv
// -----------------------------------------------------------------------------
// conv_window_buffer
// Sliding KxK window generator feeding the convolution multiply-adder tree.
// A raster-order pixel stream (at most one pixel per cycle) is written into
// K-1 line buffers. A KxK window register is shifted left on every accepted
// pixel. A flattened window is emitted for every valid-mode position, with no
// padding.
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-high reset
//   pixel_in     input pixel, row-major, top-left first
//   pixel_valid  pixel_in accepted on this edge (no backpressure)
//   window_out   flattened window; element e = r*K + cc sits in
//                bits [PIX_W*(e+1)-1 : PIX_W*e] (r = 0 is the oldest row)
//   window_valid one-cycle pulse when window_out holds a new window
//   win_row      top-left row of the emitted window
//   win_col      top-left column of the emitted window
//   frame_done   pulse coinciding with the last window of a frame
// -----------------------------------------------------------------------------
module conv_window_buffer #(
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28,
    parameter int K          = 3,
    parameter int PIX_W      = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [PIX_W-1:0]              pixel_in,
    input  logic                          pixel_valid,
    output logic [K*K*PIX_W-1:0]          window_out,
    output logic                          window_valid,
    output logic [$clog2(IMG_HEIGHT)-1:0] win_row,
    output logic [$clog2(IMG_WIDTH)-1:0]  win_col,
    output logic                          frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int NB = K - 1;
    localparam int WW = K * K * PIX_W;

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);

    logic [CW-1:0] col_reg, col_next;
    logic [RW-1:0] row_reg, row_next;
    logic          accept;
    logic          emit;
    logic          last_pos;

    // Reset wins over a simultaneous pixel, which is dropped.
    assign accept   = pixel_valid & ~reset;
    // Windows whose left columns would wrap into the previous row are never emitted.
    assign emit     = accept && (row_reg >= ROW_FIRST) && (col_reg >= COL_FIRST);
    assign last_pos = (row_reg == ROW_LAST) && (col_reg == COL_LAST);

    always_comb begin
        col_next = col_reg;
        row_next = row_reg;
        if (reset) begin
            col_next = '0;
            row_next = '0;
        end else if (accept) begin
            if (col_reg == COL_LAST) begin
                col_next = '0;
                row_next = (row_reg == ROW_LAST) ? '0 : row_reg + RW'(1);
            end else begin
                col_next = col_reg + CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            col_reg <= '0;
            row_reg <= '0;
        end else begin
            col_reg <= col_next;
            row_reg <= row_next;
        end
    end

    // -------------------------------------------------------------------------
    // Line buffers. The read port is registered and addressed with col_next.
    // This prefetches the column of the next pixel one cycle early, so tap[b]
    // already holds the pre-update buffer[b][col_reg] when that pixel arrives.
    // The read address never equals the write address on the same edge.
    // Idle cycles re-read the same column, which nothing has written since.
    // -------------------------------------------------------------------------
    logic [PIX_W-1:0] tap [NB];

    genvar gi, gj;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_line
            logic [PIX_W-1:0] line_mem [IMG_WIDTH];
            logic [PIX_W-1:0] rd_data_reg;
            logic [PIX_W-1:0] wr_data;

            if (gi == 0) begin : g_head
                assign wr_data = pixel_in;
            end else begin : g_chain
                assign wr_data = tap[gi-1];
            end

            always_ff @(posedge clock) begin
                if (accept) begin
                    line_mem[col_reg] <= wr_data;
                end
                rd_data_reg <= line_mem[col_next];
            end

            assign tap[gi] = rd_data_reg;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Window register. Every row shifts toward element 0. The rightmost
    // column is loaded top to bottom from the oldest buffer to the live pixel.
    // -------------------------------------------------------------------------
    logic [WW-1:0] win_reg, win_next;

    generate
        for (gi = 0; gi < K; gi++) begin : g_row
            for (gj = 0; gj < K; gj++) begin : g_col
                localparam int E = gi * K + gj;
                if (gj < K - 1) begin : g_shift
                    assign win_next[E*PIX_W +: PIX_W] = win_reg[(E+1)*PIX_W +: PIX_W];
                end else if (gi == K - 1) begin : g_live
                    assign win_next[E*PIX_W +: PIX_W] = pixel_in;
                end else begin : g_buf
                    assign win_next[E*PIX_W +: PIX_W] = tap[K-2-gi];
                end
            end
        end
    endgenerate

    logic [WW-1:0] window_out_reg;
    logic          window_valid_reg;
    logic [RW-1:0] win_row_reg;
    logic [CW-1:0] win_col_reg;
    logic          frame_done_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            win_reg          <= '0;
            window_out_reg   <= '0;
            window_valid_reg <= 1'b0;
            win_row_reg      <= '0;
            win_col_reg      <= '0;
            frame_done_reg   <= 1'b0;
        end else begin
            if (accept) begin
                win_reg <= win_next;
            end
            window_valid_reg <= emit;
            frame_done_reg   <= emit && last_pos;
            // Output holds the last emitted window, even though win_reg moves on.
            if (emit) begin
                window_out_reg <= win_next;
                win_row_reg    <= row_reg - ROW_FIRST;
                win_col_reg    <= col_reg - COL_FIRST;
            end
        end
    end

    assign window_out   = window_out_reg;
    assign window_valid = window_valid_reg;
    assign win_row      = win_row_reg;
    assign win_col      = win_col_reg;
    assign frame_done   = frame_done_reg;

endmodule

// File: tb/tb_conv_window_buffer.sv
// -----------------------------------------------------------------------------
// tb_conv_window_buffer
// Directed bench. Instance A is 5x5 with K=3 and instance B is 4x6 with K=2.
// Each cycle drives one pixel (or a gap), samples 1 ns after the clock edge,
// and compares every output against a small raster model of the expected
// window.
// -----------------------------------------------------------------------------
module tb_conv_window_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 5x5, K=3
    logic        reset_a;
    logic        valid_a;
    logic [7:0]  pix_a;
    logic [71:0] win_a;
    logic        wv_a;
    logic [2:0]  wr_a;
    logic [2:0]  wc_a;
    logic        fd_a;

    // Instance B: width 4, height 6, K=2
    logic        reset_b;
    logic        valid_b;
    logic [7:0]  pix_b;
    logic [31:0] win_b;
    logic        wv_b;
    logic [2:0]  wr_b;
    logic [1:0]  wc_b;
    logic        fd_b;

    conv_window_buffer #(.IMG_WIDTH(5), .IMG_HEIGHT(5), .K(3), .PIX_W(8)) dut_a (
        .clock(clk), .reset(reset_a), .pixel_in(pix_a), .pixel_valid(valid_a),
        .window_out(win_a), .window_valid(wv_a), .win_row(wr_a), .win_col(wc_a),
        .frame_done(fd_a)
    );

    conv_window_buffer #(.IMG_WIDTH(4), .IMG_HEIGHT(6), .K(2), .PIX_W(8)) dut_b (
        .clock(clk), .reset(reset_b), .pixel_in(pix_b), .pixel_valid(valid_b),
        .window_out(win_b), .window_valid(wv_b), .win_row(wr_b), .win_col(wc_b),
        .frame_done(fd_b)
    );

    int checks   = 0;
    int failures = 0;

    logic [71:0] exp_win_a;
    int          exp_row_a;
    int          exp_col_a;
    int          seen_a;

    logic [31:0] exp_win_b;
    int          exp_row_b;
    int          exp_col_b;
    int          seen_b;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected 3x3 window with top-left (r,c) on a 5-wide image of base+5*row+col.
    function automatic logic [71:0] model_a(input int base, input int r, input int c);
        logic [71:0] m;
        m = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                m[(i*3+j)*8 +: 8] = 8'(base + 5*(r+i) + (c+j));
        return m;
    endfunction

    // Expected 2x2 window with top-left (r,c) on a 4-wide image of 4*row+col.
    function automatic logic [31:0] model_b(input int r, input int c);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                m[(i*2+j)*8 +: 8] = 8'(4*(r+i) + (c+j));
        return m;
    endfunction

    task automatic step_a(input logic v, input int r, input int c, input int base);
        logic ev;
        logic efd;
        pix_a   = 8'(base + 5*r + c);
        valid_a = v;
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        ev  = v && (r >= 2) && (c >= 2);
        efd = ev && (r == 4) && (c == 4);
        if (ev) begin
            exp_win_a = model_a(base, r-2, c-2);
            exp_row_a = r - 2;
            exp_col_a = c - 2;
        end
        if (wv_a === 1'b1) begin
            seen_a++;
            $display("A window row=%0d col=%0d data=%h frame_done=%b", wr_a, wc_a, win_a, fd_a);
        end
        check("a_valid",  128'(wv_a),  128'(ev));
        check("a_window", 128'(win_a), 128'(exp_win_a));
        check("a_row",    128'(wr_a),  128'(exp_row_a));
        check("a_col",    128'(wc_a),  128'(exp_col_a));
        check("a_fdone",  128'(fd_a),  128'(efd));
    endtask

    // Pixels k0..k1 of a 5x5 frame; with gaps, 3 idle cycles after every second pixel.
    task automatic run_a(input int base, input int k0, input int k1, input bit gaps);
        for (int k = k0; k <= k1; k++) begin
            step_a(1'b1, k / 5, k % 5, base);
            if (gaps && (k % 2 == 1))
                repeat (3) step_a(1'b0, 0, 0, base);
        end
    endtask

    task automatic step_b(input int r, input int c);
        logic ev;
        logic efd;
        pix_b   = 8'(4*r + c);
        valid_b = 1'b1;
        @(posedge clk);
        #1;
        valid_b = 1'b0;
        ev  = (r >= 1) && (c >= 1);
        efd = ev && (r == 5) && (c == 3);
        if (ev) begin
            exp_win_b = model_b(r-1, c-1);
            exp_row_b = r - 1;
            exp_col_b = c - 1;
        end
        if (wv_b === 1'b1) begin
            seen_b++;
            $display("B window row=%0d col=%0d data=%h frame_done=%b", wr_b, wc_b, win_b, fd_b);
        end
        check("b_valid",  128'(wv_b),  128'(ev));
        check("b_window", 128'(win_b), 128'(exp_win_b));
        check("b_row",    128'(wr_b),  128'(exp_row_b));
        check("b_col",    128'(wc_b),  128'(exp_col_b));
        check("b_fdone",  128'(fd_b),  128'(efd));
    endtask

    task automatic run_b(input int k0, input int k1);
        for (int k = k0; k <= k1; k++)
            step_b(k / 4, k % 4);
    endtask

    initial begin
        reset_a = 1'b1; valid_a = 1'b0; pix_a = '0;
        reset_b = 1'b1; valid_b = 1'b0; pix_b = '0;
        exp_win_a = '0; exp_row_a = 0; exp_col_a = 0; seen_a = 0;
        exp_win_b = '0; exp_row_b = 0; exp_col_b = 0; seen_b = 0;
        repeat (2) @(posedge clk);
        #1;
        check("a_rst_window", 128'(win_a), 128'(0));
        check("a_rst_valid",  128'(wv_a),  128'(0));
        check("a_rst_row",    128'(wr_a),  128'(0));
        check("a_rst_col",    128'(wc_a),  128'(0));
        check("a_rst_fdone",  128'(fd_a),  128'(0));
        check("b_rst_window", 128'(win_b), 128'(0));
        check("b_rst_valid",  128'(wv_b),  128'(0));
        check("b_rst_fdone",  128'(fd_b),  128'(0));
        reset_a = 1'b0;
        reset_b = 1'b0;

        // Frame 1: basic window and full frame, pixel_valid held high.
        seen_a = 0;
        run_a(0, 0, 12, 1'b0);
        check("a_first_window", 128'(win_a), 128'(72'h0c0b0a070605020100));
        check("a_first_valid",  128'(wv_a),  128'(1));
        check("a_first_rowcol", 128'({wr_a, wc_a}), 128'(0));
        run_a(0, 13, 24, 1'b0);
        check("a_last_window", 128'(win_a), 128'(72'h1817161312110e0d0c));
        check("a_last_fdone",  128'(fd_a),  128'(1));
        check("a_last_rowcol", 128'({wr_a, wc_a}), 128'({3'd2, 3'd2}));
        check("a_count_f1", 128'(seen_a), 128'(9));

        // Frame 2 follows with no idle cycle.
        seen_a = 0;
        run_a(100, 0, 12, 1'b0);
        check("a_f2_first_window", 128'(win_a), 128'(72'h706f6e6b6a69666564));
        run_a(100, 13, 24, 1'b0);
        check("a_count_f2", 128'(seen_a), 128'(9));

        // Frame 3: gaps of 3 idle cycles after every second pixel.
        seen_a = 0;
        run_a(0, 0, 24, 1'b1);
        check("a_count_gaps", 128'(seen_a), 128'(9));

        // Mid-frame reset after 14 pixels, with a pixel offered in the reset cycle.
        run_a(0, 0, 13, 1'b0);
        reset_a = 1'b1;
        valid_a = 1'b1;
        pix_a   = 8'd14;
        @(posedge clk);
        #1;
        reset_a = 1'b0;
        valid_a = 1'b0;
        check("a_mrst_window", 128'(win_a), 128'(0));
        check("a_mrst_valid",  128'(wv_a),  128'(0));
        check("a_mrst_row",    128'(wr_a),  128'(0));
        check("a_mrst_col",    128'(wc_a),  128'(0));
        check("a_mrst_fdone",  128'(fd_a),  128'(0));
        exp_win_a = '0; exp_row_a = 0; exp_col_a = 0;
        seen_a = 0;
        run_a(0, 0, 12, 1'b0);
        check("a_rst_first_window", 128'(win_a), 128'(72'h0c0b0a070605020100));
        run_a(0, 13, 24, 1'b0);
        check("a_count_after_rst", 128'(seen_a), 128'(9));

        // Parameter sweep instance.
        seen_b = 0;
        run_b(0, 5);
        check("b_first_window", 128'(win_b), 128'(32'h05040100));
        check("b_first_rowcol", 128'({wr_b, wc_b}), 128'(0));
        run_b(6, 23);
        check("b_count",     128'(seen_b), 128'(15));
        check("b_last_row",  128'(wr_b),   128'(4));
        check("b_last_col",  128'(wc_b),   128'(2));
        check("b_last_fdone", 128'(fd_b),  128'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
